// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable serial pattern detector with registered Moore output.
// Define SEQ_DET_COUNT_EN to build the saturating match counter; otherwise match_count is tied to 0.
module seq_detector_param #(
  parameter int unsigned PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(4'b1011),
  parameter bit OVERLAP = 1'b1,
  parameter int unsigned CNT_W = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic sequence_in,
  input  logic in_valid,
  input  logic pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  output logic detector_out,
  output logic [CNT_W-1:0] match_count
);
  localparam int unsigned FW = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN);
  logic [PAT_LEN-1:0] pat_reg, pat_n, hist, hist_n, shifted;
  logic [FW-1:0] fill, fill_n;
  logic det, det_n, hit;
  always_ff @(posedge clock) begin
    if (reset) begin
      pat_reg <= PATTERN;
      hist <= '0;
      fill <= '0;
      det <= 1'b0;
    end else begin
      pat_reg <= pat_n;
      hist <= hist_n;
      fill <= fill_n;
      det <= det_n;
    end
  end
  // fill >= PAT_LEN-1 means this bit completes a full window of valid history
  always_comb begin
    shifted = {hist[PAT_LEN-2:0], sequence_in};
    hit = (fill >= FW'(PAT_LEN - 1)) && (shifted == pat_reg);
    pat_n = pat_load ? pat_in : pat_reg;
    hist_n = pat_load ? '0 : in_valid ? shifted : hist;
    fill_n = pat_load ? '0 :
             !in_valid ? fill :
             (hit && !OVERLAP) ? '0 :
             (fill == FULL) ? fill : fill + FW'(1);
    det_n = !pat_load && in_valid && hit;
  end
`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clock) begin
    if (reset) cnt <= '0;
    else if (det_n && cnt != '1) cnt <= cnt + CNT_W'(1);
  end
`endif
  always_comb begin
    detector_out = det;
`ifdef SEQ_DET_COUNT_EN
    match_count = cnt;
`else
    match_count = '0;
`endif
  end
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: scoreboard bench driving three detector configurations from one stimulus stream.
module tb_seq_detector_param;
  logic clock = 1'b0, reset = 1'b1, sequence_in = 1'b0, in_valid = 1'b0, pat_load = 1'b0;
  logic [3:0] pat_in = '0;
  logic [2:0] det;
  logic [7:0] mc0, mc1;
  logic [1:0] mc2;
  int total = 0, bad = 0;
  always #5 clock = ~clock;
  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u0 (
    .clock(clock), .reset(reset), .sequence_in(sequence_in), .in_valid(in_valid),
    .pat_load(pat_load), .pat_in(pat_in), .detector_out(det[0]), .match_count(mc0));
  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u1 (
    .clock(clock), .reset(reset), .sequence_in(sequence_in), .in_valid(in_valid),
    .pat_load(pat_load), .pat_in(pat_in), .detector_out(det[1]), .match_count(mc1));
  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(2)) u2 (
    .clock(clock), .reset(reset), .sequence_in(sequence_in), .in_valid(in_valid),
    .pat_load(pat_load), .pat_in(pat_in), .detector_out(det[2]), .match_count(mc2));
  typedef struct packed {
    logic [2:0] det;
    logic [7:0] c0, c1;
    logic [1:0] c2;
  } exp_t;
  exp_t sb[$];
  logic [3:0] m_pat[3];
  int m_bits[3][$];
  logic m_det[3];
  int m_cnt[3];
  function automatic logic [3:0] init_pat(int i);
    return i == 2 ? 4'b1111 : 4'b1011;
  endfunction
  function automatic int cnt_max(int i);
    return i == 2 ? 3 : 255;
  endfunction
  // Reference: remember the valid bits seen since the last reset/load/(non-overlap) match,
  // and report a match whenever the most recent four of them spell the pattern.
  task automatic drive(input logic r, input logic v, input logic b, input logic ld, input logic [3:0] p);
    exp_t e;
    @(posedge clock);
    #1;
    reset = r; in_valid = v; sequence_in = b; pat_load = ld; pat_in = p;
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        m_pat[i] = init_pat(i); m_bits[i].delete(); m_det[i] = 1'b0; m_cnt[i] = 0;
      end else if (ld) begin
        m_pat[i] = p; m_bits[i].delete(); m_det[i] = 1'b0;
      end else if (v) begin
        int n;
        logic hit;
        m_bits[i].push_back(int'(b));
        while (m_bits[i].size() > 4) void'(m_bits[i].pop_front());
        n = m_bits[i].size();
        hit = (n == 4);
        if (hit)
          for (int k = 0; k < 4; k++)
            if (m_bits[i][k] != int'(m_pat[i][3-k])) hit = 1'b0;
        m_det[i] = hit;
        if (hit && m_cnt[i] < cnt_max(i)) m_cnt[i]++;
        if (hit && i == 1) m_bits[i].delete();
      end else m_det[i] = 1'b0;
    end
    e.det = {m_det[2], m_det[1], m_det[0]};
`ifdef SEQ_DET_COUNT_EN
    e.c0 = 8'(m_cnt[0]); e.c1 = 8'(m_cnt[1]); e.c2 = 2'(m_cnt[2]);
`else
    e.c0 = '0; e.c1 = '0; e.c2 = '0;
`endif
    sb.push_back(e);
  endtask
  task automatic stream(input logic [31:0] bits, input int n);
    for (int k = n - 1; k >= 0; k--) drive(1'b0, 1'b1, bits[k], 1'b0, 4'b0);
  endtask
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0d want=%0d", name, $time, act, exp);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      if (sb.size() > 0) begin
        @(negedge clock);
        e = sb.pop_front();
        for (int i = 0; i < 3; i++) chk($sformatf("det%0d", i), int'(det[i]), int'(e.det[i]));
        chk("cnt0", int'(mc0), int'(e.c0));
        chk("cnt1", int'(mc1), int'(e.c1));
        chk("cnt2", int'(mc2), int'(e.c2));
      end
    end
  end
  initial begin
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b0);
    stream(32'b1011011, 7);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0);
    stream(32'b10111011, 8);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0);
    stream(32'b10, 2);
    repeat (3) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 4'b0);
    stream(32'b11, 2);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0);
    stream(32'b101, 3);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'b0110);
    stream(32'b0110, 4);
    stream(32'b1011, 4);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0);
    stream(32'h3FF, 10);
    for (int c = 0; c < 600; c++) begin
      logic r, ld;
      logic [3:0] p;
      r = ($urandom_range(0, 99) == 0);
      ld = ($urandom_range(0, 39) == 0);
      p = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'b1111;
      drive(r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), ld, p);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0);
    repeat (3) @(posedge clock);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got=%0d want=0 pending", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
